// File: rtl/cv_scale_if.sv
// Bus between cv_scale_core and its frame buffers: start/mode request, mem0 read port, mem1 write port.
// The thresh member exists only when CV_THRESH_EN is defined.
interface cv_scale_if #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 4,
    parameter int ADDR_W = 19
);
    logic              start;
    logic [1:0]        mode;
`ifdef CV_THRESH_EN
    logic [IN_W-1:0]   thresh;
`endif
    logic [IN_W-1:0]   din;
    logic [ADDR_W-1:0] addr_mem0;
    logic [ADDR_W-1:0] addr_mem1;
    logic [OUT_W-1:0]  dout;
    logic              we;
    logic              busy;
    logic              core_end;

    modport master (
        output start, output mode,
`ifdef CV_THRESH_EN
        output thresh,
`endif
        output din,
        input  addr_mem0, input addr_mem1, input dout, input we, input busy, input core_end
    );

    modport slave (
        input  start, input mode,
`ifdef CV_THRESH_EN
        input  thresh,
`endif
        input  din,
        output addr_mem0, output addr_mem1, output dout, output we, output busy, output core_end
    );
endinterface

// File: rtl/cv_scale_core.sv
// Frame raster core: reads mem0, decimates by SCALE, writes OUT_W-bit pixels to mem1.
// Optional feature macro CV_THRESH_EN adds the thresh input and the binarise mode (mode 1x).
module cv_scale_core #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int hMaxCount  = 800,
    parameter int vMaxCount  = 525,
    parameter int SCALE      = 1,
    parameter int IN_W       = 8,
    parameter int OUT_W      = 4,
    parameter int CONTINUOUS = 0,
    parameter int ADDR_W     = 19
) (
    input logic       clk24,
    input logic       rst_n,
    cv_scale_if.slave bus
);
    localparam int HW = $clog2(hMaxCount + 1);
    localparam int VW = $clog2(vMaxCount + 1);
    localparam int CW = $clog2(hMaxCount * vMaxCount + 1);
    localparam int SH = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
    localparam logic [HW-1:0]     H_LAST  = HW'(hMaxCount - 1);
    localparam logic [HW-1:0]     H_ACT   = HW'(WIDTH);
    localparam logic [VW-1:0]     V_ACT   = VW'(HEIGHT);
    localparam logic [HW-1:0]     H_MASK  = HW'(SCALE - 1);
    localparam logic [VW-1:0]     V_MASK  = VW'(SCALE - 1);
    localparam logic [CW-1:0]     C_FRAME = CW'(hMaxCount * vMaxCount - 1);
    localparam logic [ADDR_W-1:0] W_IN    = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] W_OUT   = ADDR_W'(WIDTH / SCALE);
    localparam bit                AUTO    = (CONTINUOUS != 0);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [HW-1:0]     hor;
    logic [VW-1:0]     ver;
    logic [CW-1:0]     counter;
    logic [1:0]        mode_q, mode_p;
    logic              at_end, pix_ok, valid_p;
    logic [ADDR_W-1:0] addr_p;
    logic [OUT_W-1:0]  pix;
`ifdef CV_THRESH_EN
    logic [IN_W-1:0]   thresh_q, thresh_p;
`endif

    assign at_end       = (state_q == S_RUN) && (counter == C_FRAME);
    assign bus.busy     = (state_q == S_RUN);
    assign bus.core_end = at_end;
    assign bus.addr_mem0 = (state_q == S_RUN) ? (ADDR_W'(hor) + ADDR_W'(ver) * W_IN) : '0;
    assign pix_ok = (state_q == S_RUN) && (hor < H_ACT) && (ver < V_ACT)
                    && ((hor & H_MASK) == '0) && ((ver & V_MASK) == '0);

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (at_end && !AUTO) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Raster counters sit at zero outside RUN so the first RUN cycle starts at hor=ver=0.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            hor     <= '0;
            ver     <= '0;
            counter <= '0;
        end else if (state_q == S_RUN && !at_end) begin
            counter <= counter + 1'b1;
            if (hor == H_LAST) begin
                hor <= '0;
                ver <= ver + 1'b1;
            end else begin
                hor <= hor + 1'b1;
            end
        end else begin
            hor     <= '0;
            ver     <= '0;
            counter <= '0;
        end
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
`ifdef CV_THRESH_EN
            thresh_q <= '0;
`endif
        end else if ((state_q == S_IDLE && bus.start) || (at_end && AUTO)) begin
            mode_q <= bus.mode;
`ifdef CV_THRESH_EN
            thresh_q <= bus.thresh;
`endif
        end
    end

    // Mode travels with each pixel so pixels draining across an auto-restart keep their frame's mode.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            valid_p <= 1'b0;
            addr_p  <= '0;
            mode_p  <= '0;
`ifdef CV_THRESH_EN
            thresh_p <= '0;
`endif
        end else begin
            valid_p <= pix_ok;
            addr_p  <= ADDR_W'(hor >> SH) + ADDR_W'(ver >> SH) * W_OUT;
            mode_p  <= mode_q;
`ifdef CV_THRESH_EN
            thresh_p <= thresh_q;
`endif
        end
    end

    always_comb begin
        pix = bus.din[IN_W-1 -: OUT_W];
        if (mode_p == 2'b01) pix = ~bus.din[IN_W-1 -: OUT_W];
`ifdef CV_THRESH_EN
        else if (mode_p[1]) pix = (bus.din >= thresh_p) ? '1 : '0;
`endif
    end

    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            bus.we        <= 1'b0;
            bus.addr_mem1 <= '0;
            bus.dout      <= '0;
        end else begin
            bus.we <= valid_p;
            if (valid_p) begin
                bus.addr_mem1 <= addr_p;
                bus.dout      <= pix;
            end
        end
    end
endmodule

// File: tb/tb_cv_scale_core.sv
// Directed bench for cv_scale_core: a SCALE=1/OUT_W=4 and a SCALE=2/OUT_W=8 instance share stimulus.
// Each instance reads a sync-RAM model returning the low address byte (or a constant 8'hA5).
module tb_cv_scale_core;
    localparam int W = 8, H = 4, HM = 10, VM = 6;

    logic       clk24 = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [7:0] thr;
    logic       const_din;

    int total = 0;
    int bad   = 0;

    cv_scale_if #(.IN_W(8), .OUT_W(4), .ADDR_W(19)) bus1 ();
    cv_scale_if #(.IN_W(8), .OUT_W(8), .ADDR_W(19)) bus2 ();

    cv_scale_core #(.WIDTH(W), .HEIGHT(H), .hMaxCount(HM), .vMaxCount(VM), .SCALE(1),
                    .IN_W(8), .OUT_W(4), .CONTINUOUS(0), .ADDR_W(19))
        u_dut1 (.clk24(clk24), .rst_n(rst_n), .bus(bus1.slave));

    cv_scale_core #(.WIDTH(W), .HEIGHT(H), .hMaxCount(HM), .vMaxCount(VM), .SCALE(2),
                    .IN_W(8), .OUT_W(8), .CONTINUOUS(0), .ADDR_W(19))
        u_dut2 (.clk24(clk24), .rst_n(rst_n), .bus(bus2.slave));

    always #5 clk24 = ~clk24;

    assign bus1.start = start;
    assign bus1.mode  = mode;
    assign bus2.start = start;
    assign bus2.mode  = mode;
`ifdef CV_THRESH_EN
    assign bus1.thresh = thr;
    assign bus2.thresh = thr;
`endif

    always @(posedge clk24) begin
        bus1.din <= const_din ? 8'hA5 : bus1.addr_mem0[7:0];
        bus2.din <= const_din ? 8'hA5 : bus2.addr_mem0[7:0];
    end

    logic [18:0] a1q[$];
    logic [3:0]  d1q[$];
    logic [18:0] a2q[$];
    logic [7:0]  d2q[$];
    int busy_cnt, end_cnt, end_cycle, first_wr, last_wr, wr_after_rst;
    logic busy_after;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        @(negedge clk24);
        start = 1'b0;
    endtask

    function automatic logic [7:0] pixOp(input logic [7:0] src, input logic [1:0] m, input logic cd);
        logic [7:0] v;
        v = cd ? 8'hA5 : src;
        if (m == 2'b01) return ~v;
`ifdef CV_THRESH_EN
        if (m[1]) return (v >= thr) ? 8'hFF : 8'h00;
`endif
        return v;
    endfunction

    // Runs one start request and records every write seen on both buses, sampled at negedge.
    task automatic doFrame(input logic [1:0] m, input logic [1:0] mid_m, input int reset_at);
        a1q.delete(); d1q.delete(); a2q.delete(); d2q.delete();
        busy_cnt = 0; end_cnt = 0; end_cycle = -1; first_wr = -1; last_wr = -1;
        wr_after_rst = 0; busy_after = 1'b1;
        @(negedge clk24);
        applyStimulus(m);
        for (int c = 0; c < 80; c++) begin
            if (c == reset_at) begin
                rst_n = 1'b0;
                #1;
                checkOutput("rst_we", 32'(bus1.we), 32'd0);
                checkOutput("rst_busy", 32'(bus1.busy), 32'd0);
                checkOutput("rst_addr0", 32'(bus1.addr_mem0), 32'd0);
                checkOutput("rst_addr1", 32'(bus1.addr_mem1), 32'd0);
                checkOutput("rst_dout", 32'(bus1.dout), 32'd0);
            end
            if (c == 12) mode = mid_m;
            if (bus1.busy) busy_cnt++;
            if (bus1.core_end) begin
                end_cnt++;
                end_cycle = c;
            end
            if (c == 60) busy_after = bus1.busy;
            if (bus1.we) begin
                a1q.push_back(bus1.addr_mem1);
                d1q.push_back(bus1.dout);
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                if (reset_at >= 0 && c >= reset_at) wr_after_rst++;
            end
            if (bus2.we) begin
                a2q.push_back(bus2.addr_mem1);
                d2q.push_back(bus2.dout);
                if (reset_at >= 0 && c >= reset_at) wr_after_rst++;
            end
            @(negedge clk24);
        end
    endtask

    task automatic verifyFrame(input string tag, input logic [1:0] m, input logic cd);
        int src;
        logic [7:0] e;
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd60);
        checkOutput({tag, "_end_pulses"}, 32'(end_cnt), 32'd1);
        checkOutput({tag, "_end_pos"}, 32'(end_cycle), 32'd59);
        checkOutput({tag, "_busy_drop"}, 32'(busy_after), 32'd0);
        checkOutput({tag, "_first_wr"}, 32'(first_wr), 32'd2);
        checkOutput({tag, "_last_wr"}, 32'(last_wr), 32'd39);
        checkOutput({tag, "_n_wr1"}, 32'(a1q.size()), 32'd32);
        checkOutput({tag, "_n_wr2"}, 32'(a2q.size()), 32'd8);
        for (int i = 0; i < a1q.size() && i < 32; i++) begin
            e = pixOp(8'(i), m, cd);
            checkOutput({tag, "_wr1_addr"}, 32'(a1q[i]), 32'(i));
            checkOutput({tag, "_wr1_data"}, 32'(d1q[i]), 32'(e[7:4]));
        end
        for (int i = 0; i < a2q.size() && i < 8; i++) begin
            src = (i % 4) * 2 + (i / 4) * 16;
            checkOutput({tag, "_wr2_addr"}, 32'(a2q[i]), 32'(i));
            checkOutput({tag, "_wr2_data"}, 32'(d2q[i]), 32'(pixOp(8'(src), m, cd)));
        end
    endtask

    initial begin
        logic any_out;
        rst_n = 1'b0; start = 1'b0; mode = 2'b00; thr = 8'd16; const_din = 1'b0;
        any_out = 1'b0;

        // Held in reset, start toggling must not wake anything up.
        for (int c = 0; c < 100; c++) begin
            @(negedge clk24);
            start = ~start;
            any_out = any_out | bus1.we | bus1.busy | bus1.core_end | (|bus1.addr_mem0)
                      | (|bus1.addr_mem1) | (|bus1.dout) | bus2.we | bus2.busy | (|bus2.dout);
        end
        start = 1'b0;
        checkOutput("rst_quiet", 32'(any_out), 32'd0);
        @(negedge clk24);
        rst_n = 1'b1;
        repeat (3) @(negedge clk24);
        checkOutput("idle_busy", 32'(bus1.busy), 32'd0);
        checkOutput("idle_addr0", 32'(bus1.addr_mem0), 32'd0);

        doFrame(2'b00, 2'b00, -1);
        verifyFrame("m00", 2'b00, 1'b0);

        doFrame(2'b01, 2'b01, -1);
        verifyFrame("m01", 2'b01, 1'b0);

        const_din = 1'b1;
        doFrame(2'b01, 2'b00, -1);
        verifyFrame("const_inv", 2'b01, 1'b1);
        const_din = 1'b0;

        doFrame(2'b10, 2'b10, -1);
        verifyFrame("m10", 2'b10, 1'b0);

        doFrame(2'b00, 2'b00, 25);
        checkOutput("rst_mid_no_wr", 32'(wr_after_rst), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy_cnt), 32'd25);
        rst_n = 1'b1;
        repeat (2) @(negedge clk24);
        doFrame(2'b00, 2'b00, -1);
        verifyFrame("post_rst", 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
